// File: rtl/alu_ctrl_decoder.sv
// ALU control decoder for an RV32I execute stage.
// Maps the main-control ALUOp class plus funct7/funct3 to a 4-bit ALU
// operation code and flags combinations that are not legal ALU ops.
// The decode itself is combinational; both outputs are registered, so
// they follow the sampled inputs by exactly one clock.
module alu_ctrl_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  output logic [3:0] ALUctrl,
  output logic       illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Returns {illegal, code}. Anything not explicitly legal falls back to
  // ADD with the illegal flag raised, so no input ever yields an undefined code.
  function automatic logic [4:0] decode(input logic [1:0] op,
                                        input logic [6:0] f7,
                                        input logic [2:0] f3);
    logic       base;
    logic       alt;
    logic [4:0] res;
    base = (f7 == F7_BASE);
    alt  = (f7 == F7_ALT);
    res  = {1'b1, OP_ADD};
    case (op)
      2'b00: res = {1'b0, OP_ADD};
      2'b01: res = {1'b0, OP_SUB};
      2'b10: begin
        // R-type: funct7 selects the alternate op only for ADD/SUB and SRL/SRA.
        case (f3)
          3'b000: begin
            if (base)     res = {1'b0, OP_ADD};
            else if (alt) res = {1'b0, OP_SUB};
          end
          3'b001: if (base) res = {1'b0, OP_SLL};
          3'b010: if (base) res = {1'b0, OP_SLT};
          3'b011: if (base) res = {1'b0, OP_SLTU};
          3'b100: if (base) res = {1'b0, OP_XOR};
          3'b101: begin
            if (base)     res = {1'b0, OP_SRL};
            else if (alt) res = {1'b0, OP_SRA};
          end
          3'b110: if (base) res = {1'b0, OP_OR};
          default: if (base) res = {1'b0, OP_AND};
        endcase
      end
      default: begin
        // I-type: funct7 is immediate bits except for shifts; ADDI never becomes SUB.
        case (f3)
          3'b000: res = {1'b0, OP_ADD};
          3'b001: if (base) res = {1'b0, OP_SLL};
          3'b010: res = {1'b0, OP_SLT};
          3'b011: res = {1'b0, OP_SLTU};
          3'b100: res = {1'b0, OP_XOR};
          3'b101: begin
            if (base)     res = {1'b0, OP_SRL};
            else if (alt) res = {1'b0, OP_SRA};
          end
          3'b110: res = {1'b0, OP_OR};
          default: res = {1'b0, OP_AND};
        endcase
      end
    endcase
    return res;
  endfunction

  logic [3:0] code_p0;
  logic       illegal_p0;

  // Stage 0: combinational decode of the current inputs.
  always_comb begin
    {illegal_p0, code_p0} = decode(ALUOp, Funct7, Funct3);
  end

  // Stage 1: register the decoded result; reset forces AND with no illegal flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUctrl <= OP_AND;
      illegal <= 1'b0;
    end else begin
      ALUctrl <= code_p0;
      illegal <= illegal_p0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: a rule-table reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_alu_ctrl_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic [3:0] ALUctrl;
  logic       illegal;

  int tests_run = 0;
  int tests_failed = 0;

  alu_ctrl_decoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ALUOp  (ALUOp),
    .Funct7 (Funct7),
    .Funct3 (Funct3),
    .ALUctrl(ALUctrl),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Legal-instruction table: each entry lists a class, an optional funct7
  // and funct3 match, and the resulting op. No match means illegal.
  typedef struct {
    logic [1:0] op;
    logic       f7_any;
    logic [6:0] f7;
    logic       f3_any;
    logic [2:0] f3;
    logic [3:0] code;
  } rule_t;

  rule_t rules[$];

  function automatic void add_rule(input logic [1:0] op, input logic f7_any,
                                   input logic [6:0] f7, input logic f3_any,
                                   input logic [2:0] f3, input logic [3:0] code);
    rule_t r;
    r.op = op; r.f7_any = f7_any; r.f7 = f7;
    r.f3_any = f3_any; r.f3 = f3; r.code = code;
    rules.push_back(r);
  endfunction

  function automatic void build_rules();
    // load/store and branch
    add_rule(2'b00, 1, 7'h00, 1, 3'd0, 4'd2);
    add_rule(2'b01, 1, 7'h00, 1, 3'd0, 4'd6);
    // R-type
    add_rule(2'b10, 0, 7'h00, 0, 3'd0, 4'd2);
    add_rule(2'b10, 0, 7'h20, 0, 3'd0, 4'd6);
    add_rule(2'b10, 0, 7'h00, 0, 3'd1, 4'd4);
    add_rule(2'b10, 0, 7'h00, 0, 3'd2, 4'd7);
    add_rule(2'b10, 0, 7'h00, 0, 3'd3, 4'd8);
    add_rule(2'b10, 0, 7'h00, 0, 3'd4, 4'd3);
    add_rule(2'b10, 0, 7'h00, 0, 3'd5, 4'd5);
    add_rule(2'b10, 0, 7'h20, 0, 3'd5, 4'd9);
    add_rule(2'b10, 0, 7'h00, 0, 3'd6, 4'd1);
    add_rule(2'b10, 0, 7'h00, 0, 3'd7, 4'd0);
    // I-type
    add_rule(2'b11, 1, 7'h00, 0, 3'd0, 4'd2);
    add_rule(2'b11, 0, 7'h00, 0, 3'd1, 4'd4);
    add_rule(2'b11, 1, 7'h00, 0, 3'd2, 4'd7);
    add_rule(2'b11, 1, 7'h00, 0, 3'd3, 4'd8);
    add_rule(2'b11, 1, 7'h00, 0, 3'd4, 4'd3);
    add_rule(2'b11, 0, 7'h00, 0, 3'd5, 4'd5);
    add_rule(2'b11, 0, 7'h20, 0, 3'd5, 4'd9);
    add_rule(2'b11, 1, 7'h00, 0, 3'd6, 4'd1);
    add_rule(2'b11, 1, 7'h00, 0, 3'd7, 4'd0);
  endfunction

  function automatic void model(input logic [1:0] op, input logic [6:0] f7,
                                input logic [2:0] f3,
                                output logic [3:0] code, output logic ill);
    code = 4'd2;
    ill  = 1'b1;
    foreach (rules[i]) begin
      if (rules[i].op == op && (rules[i].f7_any || rules[i].f7 == f7) &&
          (rules[i].f3_any || rules[i].f3 == f3)) begin
        code = rules[i].code;
        ill  = 1'b0;
        break;
      end
    end
  endfunction

  // Model registers: what the outputs must hold after each rising edge.
  logic [3:0] exp_code;
  logic       exp_ill;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_code = 4'd0;
      exp_ill  = 1'b0;
    end else begin
      model(ALUOp, Funct7, Funct3, exp_code, exp_ill);
    end
    model_valid = 1'b1;
  end

  // Compare process: mid-cycle check of the DUT against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      tests_run++;
      if (ALUctrl !== exp_code || illegal !== exp_ill) begin
        tests_failed++;
        $display("FAIL model_cmp op=%b f7=%b f3=%b: got ctrl=%b ill=%b, need ctrl=%b ill=%b",
                 ALUOp, Funct7, Funct3, ALUctrl, illegal, exp_code, exp_ill);
      end
    end
  end

  // Drive one vector, let one edge pass, then check against literal values.
  task automatic apply(input string name, input logic rst_v, input logic [1:0] op,
                       input logic [6:0] f7, input logic [2:0] f3,
                       input logic [3:0] need_code, input logic need_ill);
    rst_n  = rst_v;
    ALUOp  = op;
    Funct7 = f7;
    Funct3 = f3;
    @(posedge clk);
    #1;
    tests_run++;
    if (ALUctrl !== need_code || illegal !== need_ill) begin
      tests_failed++;
      $display("FAIL %s: got ctrl=%b ill=%b, need ctrl=%b ill=%b",
               name, ALUctrl, illegal, need_code, need_ill);
    end
  endtask

  initial begin
    build_rules();
    rst_n  = 1'b0;
    ALUOp  = 2'b10;
    Funct7 = 7'b0100000;
    Funct3 = 3'b000;
    @(posedge clk);
    #1;

    // Reset overrides inputs that would otherwise decode to SUB.
    apply("reset",        0, 2'b10, 7'b0100000, 3'b000, 4'b0000, 0);
    apply("r_add",        1, 2'b10, 7'b0000000, 3'b000, 4'b0010, 0);
    apply("r_sub",        1, 2'b10, 7'b0100000, 3'b000, 4'b0110, 0);
    apply("r_and",        1, 2'b10, 7'b0000000, 3'b111, 4'b0000, 0);
    apply("r_or",         1, 2'b10, 7'b0000000, 3'b110, 4'b0001, 0);
    apply("r_xor",        1, 2'b10, 7'b0000000, 3'b100, 4'b0011, 0);
    apply("r_slt",        1, 2'b10, 7'b0000000, 3'b010, 4'b0111, 0);
    apply("r_sltu",       1, 2'b10, 7'b0000000, 3'b011, 4'b1000, 0);
    apply("r_sll",        1, 2'b10, 7'b0000000, 3'b001, 4'b0100, 0);
    apply("r_srl",        1, 2'b10, 7'b0000000, 3'b101, 4'b0101, 0);
    apply("r_sra",        1, 2'b10, 7'b0100000, 3'b101, 4'b1001, 0);
    apply("ls_add",       1, 2'b00, 7'b1111111, 3'b101, 4'b0010, 0);
    apply("br_sub",       1, 2'b01, 7'b0100000, 3'b111, 4'b0110, 0);
    apply("i_addi_f7",    1, 2'b11, 7'b0100000, 3'b000, 4'b0010, 0);
    apply("i_srai",       1, 2'b11, 7'b0100000, 3'b101, 4'b1001, 0);
    apply("i_srli",       1, 2'b11, 7'b0000000, 3'b101, 4'b0101, 0);
    apply("i_andi_imm",   1, 2'b11, 7'b1010101, 3'b111, 4'b0000, 0);
    apply("i_slli_bad",   1, 2'b11, 7'b0100000, 3'b001, 4'b0010, 1);
    apply("i_sri_bad",    1, 2'b11, 7'b0000001, 3'b101, 4'b0010, 1);
    apply("r_bad_f7",     1, 2'b10, 7'b0000001, 3'b000, 4'b0010, 1);
    apply("r_and_alt",    1, 2'b10, 7'b0100000, 3'b111, 4'b0010, 1);
    apply("r_recover",    1, 2'b10, 7'b0000000, 3'b110, 4'b0001, 0);
    apply("mid_reset",    0, 2'b10, 7'b0000001, 3'b000, 4'b0000, 0);
    apply("post_reset",   1, 2'b01, 7'b0000000, 3'b000, 4'b0110, 0);

    // Back-to-back sweep, changing every cycle; the model checks each one.
    for (int op = 0; op < 4; op++) begin
      for (int k = 0; k < 6; k++) begin
        for (int f3 = 0; f3 < 8; f3++) begin
          logic [6:0] f7_list [6];
          f7_list = '{7'h00, 7'h20, 7'h01, 7'h7f, 7'h40, 7'h21};
          rst_n  = 1'b1;
          ALUOp  = op[1:0];
          Funct7 = f7_list[k];
          Funct3 = f3[2:0];
          @(posedge clk);
          #1;
        end
      end
    end

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
